// File: rtl/emergency_sequencer.sv
// rtl/emergency_sequencer.sv - emergency stop sequencer for an elevator car
//
// Purpose: on an SOS request, inhibits the drive, waits for the car to stop
// (or times out), engages the brake, opens the doors when at a landing,
// sounds the alarm, and releases the brake after the SOS clears.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sos_mode      in   1 = emergency requested
//   tick          in   one-clk timebase strobe
//   moving        in   1 = car in motion
//   at_floor      in   1 = car aligned with a landing
//   motor_inhibit out  1 = drive suppressed
//   brake         out  1 = brake engaged
//   door_open_req out  1 = request door opening
//   alarm         out  audible alarm drive
//   state         out  IDLE=0 DECEL=1 BRAKE=2 DOOR=3 HOLD=4 RELEASE=5
//   stop_fault    out  sticky stop-timeout flag
//
// Optional feature: define SOS_TIMEOUT_FAULT_EN to implement the sticky
// stop_fault register; otherwise stop_fault is constant 0.

module emergency_sequencer #(
  parameter int unsigned STOP_TIMEOUT  = 8,
  parameter int unsigned ALARM_HALF    = 4,
  parameter int unsigned RELEASE_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sos_mode,
  input  logic       tick,
  input  logic       moving,
  input  logic       at_floor,
  output logic       motor_inhibit,
  output logic       brake,
  output logic       door_open_req,
  output logic       alarm,
  output logic [2:0] state,
  output logic       stop_fault
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECEL   = 3'd1;
  localparam logic [2:0] S_BRAKE   = 3'd2;
  localparam logic [2:0] S_DOOR    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam logic [15:0] STOP_LAST = 16'(STOP_TIMEOUT - 1);
  localparam logic [15:0] HALF_LAST = 16'(ALARM_HALF - 1);
  localparam logic [15:0] REL_LAST  = 16'(RELEASE_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] acnt_q, acnt_d;
  logic        alarm_q, alarm_d;
  logic        armed_q, armed_d;
  logic        motor_inhibit_q, motor_inhibit_d;
  logic        brake_q, brake_d;
  logic        door_q, door_d;
  logic        timeout;

  function automatic logic alarm_state(input logic [2:0] s);
    return (s == S_DECEL) || (s == S_BRAKE) || (s == S_DOOR) || (s == S_HOLD);
  endfunction

  // Next state
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      // The first edge after reset release only arms the sequencer, so an
      // SOS level already present at release starts DECEL one edge later.
      S_IDLE:    if (sos_mode && armed_q) state_d = S_DECEL;
      S_DECEL: begin
        // A stop reported on the timeout edge is a normal stop.
        if (!moving) begin
          state_d = S_BRAKE;
        end else if (tick && (cnt_q == STOP_LAST)) begin
          state_d = S_BRAKE;
          timeout = 1'b1;
        end
      end
      S_BRAKE:   state_d = at_floor ? S_DOOR : S_HOLD;
      S_DOOR:    if (!sos_mode) state_d = S_RELEASE;
      S_HOLD:    if (!sos_mode) state_d = S_RELEASE;
      S_RELEASE: begin
        if (sos_mode) begin
          state_d = S_BRAKE;
        end else if (tick && (cnt_q == REL_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_BRAKE;
    endcase
  end

  // State tick counter: cleared on every state change, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Alarm phase runs continuously across DECEL/BRAKE/DOOR/HOLD and restarts
  // high whenever that group is entered from outside it.
  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (!alarm_state(state_d)) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (!alarm_state(state_q)) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (tick) begin
      if (acnt_q == HALF_LAST) begin
        alarm_d = ~alarm_q;
        acnt_d  = '0;
      end else begin
        acnt_d = acnt_q + 16'd1;
      end
    end
  end

  // Control outputs are decoded from the next state so the registered
  // outputs line up with the registered state.
  always_comb begin
    armed_d         = 1'b1;
    motor_inhibit_d = (state_d != S_IDLE);
    brake_d         = (state_d == S_BRAKE) || (state_d == S_DOOR) ||
                      (state_d == S_HOLD)  || (state_d == S_RELEASE);
    door_d          = (state_d == S_DOOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      acnt_q          <= '0;
      alarm_q         <= 1'b0;
      armed_q         <= 1'b0;
      motor_inhibit_q <= 1'b0;
      brake_q         <= 1'b0;
      door_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      acnt_q          <= acnt_d;
      alarm_q         <= alarm_d;
      armed_q         <= armed_d;
      motor_inhibit_q <= motor_inhibit_d;
      brake_q         <= brake_d;
      door_q          <= door_d;
    end
  end

`ifdef SOS_TIMEOUT_FAULT_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q | timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign stop_fault = fault_q;
`else
  logic timeout_unused;
  assign timeout_unused = timeout;
  assign stop_fault     = 1'b0;
`endif

  assign state         = state_q;
  assign motor_inhibit = motor_inhibit_q;
  assign brake         = brake_q;
  assign door_open_req = door_q;
  assign alarm         = alarm_q;

endmodule
